// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    REDIRECT = 2'd1,
    ERROR    = 2'd2
  } pc_seq_state_t;

  localparam int unsigned PC_STEP    = 4;
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

  // A target is unusable if it is not word aligned or does not fit in the PC.
  function automatic logic target_bad(input logic [31:0] target, input int unsigned pc_w);
    return ((target & ALIGN_MASK) != 32'd0) || ((target >> pc_w) != 32'd0);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction that returns while IF/ID is stalled.
module fetch_skid #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [PC_W-1:0] load_pc,
  output logic            valid,
  output logic [PC_W-1:0] pc
);

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the fetch PC, sequences instruction-memory requests and applies branch redirects.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [31:0]     br_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic [PC_W-1:0] pc,
  output logic            ifid_valid,
  output logic [PC_W-1:0] ifid_pc,
  output logic            flush,
  output logic            addr_err
);

  pc_seq_state_t   state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, tgt_q, tgt_d, ifid_pc_d;
  logic            req_q, req_d, ifid_valid_d, flush_d, err_d;
  logic            acked, bad;
  logic            skid_load, skid_drain, skid_clear, skid_valid, skid_valid_d;
  logic [PC_W-1:0] skid_pc;

  fetch_skid #(.PC_W(PC_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (skid_clear),
    .load_pc (pc_q),
    .valid   (skid_valid),
    .pc      (skid_pc)
  );

  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    req_d        = req_q;
    ifid_valid_d = ifid_valid;
    ifid_pc_d    = ifid_pc;
    flush_d      = 1'b0;
    err_d        = addr_err;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    skid_clear   = 1'b0;
    skid_valid_d = skid_valid;
    acked        = req_q && imem_ack;
    bad          = target_bad(br_target, PC_W);

    case (state_q)
      FETCH, REDIRECT: begin
        if (br_taken) begin
          flush_d      = 1'b1;
          ifid_valid_d = 1'b0;
          skid_clear   = 1'b1;
          if (bad) begin
            state_d = ERROR;
            err_d   = 1'b1;
            req_d   = 1'b0;
          end else if (!req_q || acked) begin
            pc_d    = br_target[PC_W-1:0];
            state_d = FETCH;
            req_d   = 1'b1;
          end else begin
            tgt_d   = br_target[PC_W-1:0];
            state_d = REDIRECT;
            req_d   = 1'b1;
          end
        end else if (state_q == REDIRECT) begin
          // Wrong-path request must still complete; its data is dropped.
          ifid_valid_d = 1'b0;
          req_d        = 1'b1;
          if (acked) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end else begin
          if (stall) begin
            skid_load = acked;
          end else if (skid_valid) begin
            skid_drain   = 1'b1;
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc;
          end else begin
            ifid_valid_d = acked;
            if (acked) ifid_pc_d = pc_q;
          end
          if (acked) pc_d = pc_q + PC_W'(PC_STEP);
          skid_valid_d = skid_load || (skid_valid && !skid_drain);
          // Outstanding requests persist; a new one waits while nowhere is free to land.
          req_d = (req_q && !acked) || !(skid_valid_d || (stall && ifid_valid_d));
        end
      end
      ERROR: begin
        req_d        = 1'b0;
        ifid_valid_d = 1'b0;
        err_d        = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      req_q      <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      flush      <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      req_q      <= req_d;
      ifid_valid <= ifid_valid_d;
      ifid_pc    <= ifid_pc_d;
      flush      <= flush_d;
      addr_err   <= err_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequencing, wait states, redirects, stall skid, address errors.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        imem_ack = 1'b0;
  logic        imem_req, ifid_valid, flush, addr_err;
  logic [8:0]  imem_addr, pc, ifid_pc;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_W(9), .RESET_PC(9'h000)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .pc         (pc),
    .ifid_valid (ifid_valid),
    .ifid_pc    (ifid_pc),
    .flush      (flush),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; imem_ack = 1'b1;
    tick(); tick();
    checks++; if (pc !== 9'h000) begin errors++; $display("FAIL rst_pc: got %h expected %h", pc, 9'h000); end
    checks++; if ({imem_req, ifid_valid, flush, addr_err} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b expected %b", {imem_req, ifid_valid, flush, addr_err}, 4'b0000); end
    checks++; if (ifid_pc !== 9'h000) begin errors++; $display("FAIL rst_ifid_pc: got %h expected %h", ifid_pc, 9'h000); end
    reset = 1'b0; imem_ack = 1'b0;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 9'h000}) begin errors++; $display("FAIL first_req: got %b/%h expected 1/000", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait;
    logic [8:0] exp_pc, exp_ifid;
    imem_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 9'(4 * i);
      exp_ifid = 9'(4 * (i - 1));
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL zw_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
      checks++; if ({ifid_valid, ifid_pc} !== {1'b1, exp_ifid}) begin errors++; $display("FAIL zw_ifid[%0d]: got %b/%h expected 1/%h", i, ifid_valid, ifid_pc, exp_ifid); end
    end
    repeat (124) tick();
    checks++; if (pc !== 9'h1FC) begin errors++; $display("FAIL zw_pc_508: got %h expected %h", pc, 9'h1FC); end
    tick();
    checks++; if (pc !== 9'h000) begin errors++; $display("FAIL zw_wrap: got %h expected %h", pc, 9'h000); end
    checks++; if (ifid_pc !== 9'h1FC) begin errors++; $display("FAIL zw_wrap_ifid: got %h expected %h", ifid_pc, 9'h1FC); end
    imem_ack = 1'b0;
  endtask

  task automatic test_delayed_ack;
    int rises = 0;
    logic prev_valid;
    prev_valid = ifid_valid;
    for (int c = 0; c < 3; c++) begin
      checks++; if ({imem_req, imem_addr} !== {1'b1, 9'h000}) begin errors++; $display("FAIL dly_hold[%0d]: got %b/%h expected 1/000", c, imem_req, imem_addr); end
      if (c == 2) imem_ack = 1'b1;
      tick();
      if (ifid_valid && !prev_valid) rises++;
      prev_valid = ifid_valid;
    end
    imem_ack = 1'b0;
    checks++; if ({ifid_valid, ifid_pc, pc} !== {1'b1, 9'h000, 9'h004}) begin errors++; $display("FAIL dly_result: got %b/%h/%h expected 1/000/004", ifid_valid, ifid_pc, pc); end
    tick();
    if (ifid_valid && !prev_valid) rises++;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL dly_valid_drop: got %b expected 0", ifid_valid); end
    checks++; if (rises != 1) begin errors++; $display("FAIL dly_rises: got %0d expected 1", rises); end
  endtask

  task automatic test_redirect_idle;
    reset = 1'b1;
    tick();
    reset = 1'b0; imem_ack = 1'b1;
    br_taken = 1'b1; br_target = 32'h40;
    tick();
    br_taken = 1'b0; imem_ack = 1'b0;
    checks++; if ({flush, ifid_valid} !== 2'b10) begin errors++; $display("FAIL rdi_flush: got %b expected 10", {flush, ifid_valid}); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 9'h040}) begin errors++; $display("FAIL rdi_addr: got %b/%h expected 1/040", imem_req, imem_addr); end
    tick();
    checks++; if ({flush, ifid_valid} !== 2'b00) begin errors++; $display("FAIL rdi_pulse: got %b expected 00", {flush, ifid_valid}); end
    // Redirect coinciding with the ack: acked data at 0x40 must be dropped.
    imem_ack = 1'b1; br_taken = 1'b1; br_target = 32'h20;
    tick();
    imem_ack = 1'b0; br_taken = 1'b0;
    checks++; if ({flush, ifid_valid, pc} !== {2'b10, 9'h020}) begin errors++; $display("FAIL rdi_ack_same: got %b/%h expected 10/020", {flush, ifid_valid}, pc); end
  endtask

  task automatic test_redirect_outstanding;
    br_taken = 1'b1; br_target = 32'h80;
    tick();
    br_taken = 1'b0;
    checks++; if (dut.state_q !== REDIRECT) begin errors++; $display("FAIL rdo_state: got %0d expected %0d", dut.state_q, REDIRECT); end
    checks++; if ({flush, imem_req, imem_addr} !== {2'b11, 9'h020}) begin errors++; $display("FAIL rdo_hold: got %b/%h expected 11/020", {flush, imem_req}, imem_addr); end
    tick();
    checks++; if ({flush, imem_req, imem_addr} !== {2'b01, 9'h020}) begin errors++; $display("FAIL rdo_wait: got %b/%h expected 01/020", {flush, imem_req}, imem_addr); end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if ({ifid_valid, imem_req, imem_addr} !== {2'b01, 9'h080}) begin errors++; $display("FAIL rdo_target: got %b/%h expected 01/080", {ifid_valid, imem_req}, imem_addr); end
    checks++; if (dut.state_q !== FETCH) begin errors++; $display("FAIL rdo_back: got %0d expected %0d", dut.state_q, FETCH); end
  endtask

  task automatic test_stall;
    imem_ack = 1'b1;
    tick();
    checks++; if ({ifid_valid, ifid_pc, pc} !== {1'b1, 9'h080, 9'h084}) begin errors++; $display("FAIL st_pre: got %b/%h/%h expected 1/080/084", ifid_valid, ifid_pc, pc); end
    stall = 1'b1; imem_ack = 1'b0;
    tick();
    checks++; if ({ifid_valid, ifid_pc, imem_req, imem_addr} !== {1'b1, 9'h080, 1'b1, 9'h084}) begin errors++; $display("FAIL st_c1: got %b/%h/%b/%h expected 1/080/1/084", ifid_valid, ifid_pc, imem_req, imem_addr); end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if ({ifid_valid, ifid_pc, imem_req, pc} !== {1'b1, 9'h080, 1'b0, 9'h088}) begin errors++; $display("FAIL st_c2: got %b/%h/%b/%h expected 1/080/0/088", ifid_valid, ifid_pc, imem_req, pc); end
    for (int c = 3; c <= 4; c++) begin
      tick();
      checks++; if ({ifid_valid, ifid_pc, imem_req} !== {1'b1, 9'h080, 1'b0}) begin errors++; $display("FAIL st_c%0d: got %b/%h/%b expected 1/080/0", c, ifid_valid, ifid_pc, imem_req); end
    end
    stall = 1'b0;
    tick();
    checks++; if ({ifid_valid, ifid_pc, imem_req, imem_addr} !== {1'b1, 9'h084, 1'b1, 9'h088}) begin errors++; $display("FAIL st_drain: got %b/%h/%b/%h expected 1/084/1/088", ifid_valid, ifid_pc, imem_req, imem_addr); end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if ({ifid_valid, ifid_pc, pc} !== {1'b1, 9'h088, 9'h08C}) begin errors++; $display("FAIL st_next: got %b/%h/%h expected 1/088/08c", ifid_valid, ifid_pc, pc); end
  endtask

  task automatic test_addr_err;
    logic [31:0] bad_targets [2];
    bad_targets[0] = 32'h42;
    bad_targets[1] = 32'h1000;
    for (int t = 0; t < 2; t++) begin
      br_taken = 1'b1; br_target = bad_targets[t];
      tick();
      br_taken = 1'b0; imem_ack = 1'b1;
      checks++; if ({addr_err, imem_req, flush, ifid_valid} !== 4'b1010) begin errors++; $display("FAIL err_enter[%0d]: got %b expected 1010", t, {addr_err, imem_req, flush, ifid_valid}); end
      repeat (3) tick();
      checks++; if ({addr_err, imem_req, ifid_valid} !== 3'b100) begin errors++; $display("FAIL err_sticky[%0d]: got %b expected 100", t, {addr_err, imem_req, ifid_valid}); end
      reset = 1'b1;
      tick();
      checks++; if ({addr_err, imem_req, ifid_valid, pc} !== {3'b000, 9'h000}) begin errors++; $display("FAIL err_reset[%0d]: got %b/%h expected 000/000", t, {addr_err, imem_req, ifid_valid}, pc); end
      reset = 1'b0; imem_ack = 1'b0;
      tick();
      checks++; if ({imem_req, imem_addr} !== {1'b1, 9'h000}) begin errors++; $display("FAIL err_restart[%0d]: got %b/%h expected 1/000", t, imem_req, imem_addr); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_redirect_idle();
    test_redirect_outstanding();
    test_stall();
    test_addr_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
